dca_lsu_inst_sequencer: RTL and testbench

DCA_LSU_INST_SEQUENCER -- requirements
Module: dca_lsu_inst_sequencer

---
 rtl/dca_lsu_inst_sequencer.sv | 140 ++++++++++++++
 tb/tb_dca_lsu_inst_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_lsu_inst_sequencer.sv
// LSU instruction sequencer: gates operand channels, hands one instruction at a time
// downstream, and tracks outstanding write credits for fences and group drains.
module dca_lsu_inst_sequencer #(
    parameter  int NUM_CH       = 3,
    parameter  int BW_INST      = 32,
    parameter  int CREDIT_DEPTH = 4,
    localparam int BW_CREDIT    = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 inst_valid,
    input  logic [BW_INST-1:0]   inst_data,
    input  logic [NUM_CH-1:0]    inst_ch_req,
    input  logic                 inst_wr,
    input  logic                 inst_fence,
    input  logic                 inst_last,
    output logic                 inst_ready,
    input  logic [NUM_CH-1:0]    ch_ready,
    output logic [NUM_CH-1:0]    ch_issue,
    output logic                 down_valid,
    output logic [BW_INST-1:0]   down_data,
    input  logic                 down_done,
    input  logic                 wr_ack,
    output logic [BW_CREDIT-1:0] credit_count,
    output logic                 busy,
    output logic                 group_done,
    output logic                 err_underflow
);

    // state     | meaning
    // IDLE      | ready to accept the next instruction
    // WAIT_DONE | instruction presented downstream, waiting for down_done
    // DRAIN     | last instruction of a group done, waiting for credits to return
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        DRAIN     = 2'd2
    } state_t;

    localparam logic [BW_CREDIT-1:0] CREDIT_MAX = BW_CREDIT'(CREDIT_DEPTH);
    localparam logic [BW_CREDIT-1:0] CREDIT_ONE = BW_CREDIT'(1);

    state_t state_q;
    state_t state_d;
    logic   last_q;
    logic   accept;
    logic   ch_ok;
    logic   credit_ok;
    logic   fence_ok;
    logic   drain_done;
    logic   credit_inc;
    logic   credit_dec;

    // every requested channel must be ready; unrequested channels are don't-care
    assign ch_ok     = &(ch_ready | ~inst_ch_req);
    assign credit_ok = ~inst_wr | (credit_count < CREDIT_MAX);
    assign fence_ok  = ~inst_fence | (credit_count == '0);

    // rst and clear gate accept so nothing is handed out while control is being reset
    assign accept = ~rst & ~clear & enable & inst_valid & (state_q == IDLE)
                  & ch_ok & credit_ok & fence_ok;

    assign drain_done = (state_q == DRAIN)
                      & ((credit_count == '0) | ((credit_count == CREDIT_ONE) & wr_ack));

    assign inst_ready = accept;
    assign ch_issue   = accept ? inst_ch_req : '0;
    assign down_valid = (state_q == WAIT_DONE);
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        group_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (enable && down_done) begin
                    state_d = last_q ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    group_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear) begin
            state_d    = IDLE;
            group_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_data <= '0;
            last_q    <= 1'b0;
        end else if (accept) begin
            down_data <= inst_data;
            last_q    <= inst_last;
        end
    end

    // credits keep counting through clear and regardless of enable
    assign credit_inc = accept & inst_wr;
    assign credit_dec = wr_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_count  <= '0;
            err_underflow <= 1'b0;
        end else if (credit_inc && !credit_dec) begin
            credit_count <= credit_count + CREDIT_ONE;
        end else if (credit_dec && !credit_inc) begin
            if (credit_count == '0) begin
                err_underflow <= 1'b1;
            end else begin
                credit_count <= credit_count - CREDIT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_dca_lsu_inst_sequencer.sv
// Bench for dca_lsu_inst_sequencer: issued instruction words are queued on accept
// and compared against down_data when the downstream handshake completes.
module tb_dca_lsu_inst_sequencer;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        enable;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [2:0]  inst_ch_req;
    logic        inst_wr;
    logic        inst_fence;
    logic        inst_last;
    logic        inst_ready;
    logic [2:0]  ch_ready;
    logic [2:0]  ch_issue;
    logic        down_valid;
    logic [31:0] down_data;
    logic        down_done;
    logic        wr_ack;
    logic [2:0]  credit_count;
    logic        busy;
    logic        group_done;
    logic        err_underflow;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    dca_lsu_inst_sequencer #(
        .NUM_CH      (3),
        .BW_INST     (32),
        .CREDIT_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .enable       (enable),
        .inst_valid   (inst_valid),
        .inst_data    (inst_data),
        .inst_ch_req  (inst_ch_req),
        .inst_wr      (inst_wr),
        .inst_fence   (inst_fence),
        .inst_last    (inst_last),
        .inst_ready   (inst_ready),
        .ch_ready     (ch_ready),
        .ch_issue     (ch_issue),
        .down_valid   (down_valid),
        .down_data    (down_data),
        .down_done    (down_done),
        .wr_ack       (wr_ack),
        .credit_count (credit_count),
        .busy         (busy),
        .group_done   (group_done),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: compare on each completed downstream handshake
    always @(negedge clk) begin
        if (!rst && down_valid && down_done && enable) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                chk("down_data", down_data, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inst(input logic [31:0] d, input logic [2:0] req,
                              input logic wr, input logic fence, input logic last);
        inst_valid  = 1'b1;
        inst_data   = d;
        inst_ch_req = req;
        inst_wr     = wr;
        inst_fence  = fence;
        inst_last   = last;
        #1;
    endtask

    task automatic wait_accept(input string tag);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (inst_ready) begin
                seen = 1;
                break;
            end
            cyc();
        end
        if (!seen) begin
            chk(tag, 32'd0, 32'd1);
        end else begin
            exp_q.push_back(inst_data);
        end
        cyc();
        inst_valid = 1'b0;
        inst_wr    = 1'b0;
        inst_fence = 1'b0;
        inst_last  = 1'b0;
    endtask

    task automatic finish_inst(input string tag);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (down_valid) begin
                seen = 1;
                break;
            end
            cyc();
        end
        if (!seen) chk(tag, 32'd0, 32'd1);
        down_done = 1'b1;
        cyc();
        down_done = 1'b0;
    endtask

    task automatic ack();
        wr_ack = 1'b1;
        cyc();
        wr_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; enable = 1'b1;
        inst_valid = 1'b0; inst_data = '0; inst_ch_req = '0;
        inst_wr = 1'b0; inst_fence = 1'b0; inst_last = 1'b0;
        ch_ready = 3'b111; down_done = 1'b0; wr_ack = 1'b0;

        // outputs held low during reset even with a valid instruction offered
        #3;
        drive_inst(32'h11, 3'b101, 1'b0, 1'b0, 1'b0);
        chk("rst_inst_ready", inst_ready, 0);
        chk("rst_ch_issue", ch_issue, 0);
        chk("rst_down_valid", down_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_group_done", group_done, 0);
        chk("rst_credit", credit_count, 0);
        chk("rst_down_data", down_data, 0);
        inst_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // basic issue
        ch_ready = 3'b101;
        drive_inst(32'hA5, 3'b101, 1'b0, 1'b0, 1'b0);
        chk("basic_inst_ready", inst_ready, 1);
        chk("basic_ch_issue", ch_issue, 3'b101);
        wait_accept("basic_accept_timeout");
        chk("basic_down_valid", down_valid, 1);
        chk("basic_busy", busy, 1);
        // down_done ignored while enable is low
        enable = 1'b0; down_done = 1'b1;
        cyc();
        down_done = 1'b0; enable = 1'b1;
        chk("noenable_hold_valid", down_valid, 1);
        chk("noenable_hold_data", down_data, 32'hA5);
        finish_inst("basic_done_timeout");
        chk("basic_idle", busy, 0);
        chk("basic_valid_low", down_valid, 0);

        // requested channel not ready blocks issue
        ch_ready = 3'b001;
        drive_inst(32'h5A, 3'b011, 1'b0, 1'b0, 1'b0);
        chk("chblock_ready", inst_ready, 0);
        chk("chblock_issue", ch_issue, 0);
        ch_ready = 3'b111;
        #1;
        chk("chunblock_issue", ch_issue, 3'b011);
        wait_accept("chunblock_timeout");
        finish_inst("chunblock_done_timeout");

        // credit full
        for (int i = 0; i < 4; i++) begin
            drive_inst(32'h100 + i, 3'b001, 1'b1, 1'b0, 1'b0);
            wait_accept("credit_fill_timeout");
            finish_inst("credit_fill_done_timeout");
        end
        chk("credit_full", credit_count, 4);
        drive_inst(32'h200, 3'b001, 1'b1, 1'b0, 1'b0);
        chk("credit_block", inst_ready, 0);
        cyc();
        chk("credit_block2", inst_ready, 0);
        wr_ack = 1'b1;
        #1;
        chk("credit_ack_nocomb", inst_ready, 0);
        cyc();
        wr_ack = 1'b0;
        #1;
        chk("credit_after_ack", credit_count, 3);
        chk("credit_reopen", inst_ready, 1);
        wait_accept("credit_reopen_timeout");
        finish_inst("credit_reopen_done_timeout");
        chk("credit_refull", credit_count, 4);

        // fence
        ack();
        ack();
        drive_inst(32'h300, 3'b010, 1'b0, 1'b1, 1'b0);
        chk("fence_stall2", inst_ready, 0);
        ack();
        #1;
        chk("fence_stall1", inst_ready, 0);
        ack();
        #1;
        chk("fence_count0", credit_count, 0);
        chk("fence_accept", inst_ready, 1);
        wait_accept("fence_timeout");
        finish_inst("fence_done_timeout");

        // group drain: accept cycle 1, down_done cycle 3, wr_ack cycle 6
        drive_inst(32'h400, 3'b100, 1'b1, 1'b0, 1'b1);
        wait_accept("drain_accept_timeout");
        cyc();
        down_done = 1'b1;
        cyc();
        down_done = 1'b0;
        chk("drain_c4_busy", busy, 1);
        chk("drain_c4_valid", down_valid, 0);
        chk("drain_c4_done", group_done, 0);
        cyc();
        chk("drain_c5_busy", busy, 1);
        chk("drain_c5_done", group_done, 0);
        cyc();
        wr_ack = 1'b1;
        #1;
        chk("drain_c6_done", group_done, 1);
        cyc();
        wr_ack = 1'b0;
        #1;
        chk("drain_c7_busy", busy, 0);
        chk("drain_c7_done", group_done, 0);
        chk("drain_c7_credit", credit_count, 0);

        // simultaneous increment and ack, then underflow
        drive_inst(32'h500, 3'b001, 1'b1, 1'b0, 1'b0);
        wait_accept("simul_pre_timeout");
        finish_inst("simul_pre_done_timeout");
        drive_inst(32'h501, 3'b001, 1'b1, 1'b0, 1'b0);
        wr_ack = 1'b1;
        wait_accept("simul_timeout");
        wr_ack = 1'b0;
        chk("simul_credit", credit_count, 1);
        finish_inst("simul_done_timeout");
        ack();
        chk("uf_pre_flag", err_underflow, 0);
        ack();
        chk("uf_credit", credit_count, 0);
        chk("uf_flag", err_underflow, 1);
        cyc();
        chk("uf_sticky", err_underflow, 1);

        // clear mid WAIT_DONE with three credits outstanding
        for (int i = 0; i < 3; i++) begin
            drive_inst(32'h600 + i, 3'b010, 1'b1, 1'b0, 1'b0);
            wait_accept("clr_fill_timeout");
            finish_inst("clr_fill_done_timeout");
        end
        drive_inst(32'h610, 3'b010, 1'b0, 1'b0, 1'b0);
        wait_accept("clr_accept_timeout");
        chk("clr_pre_valid", down_valid, 1);
        clear = 1'b1;
        cyc();
        exp_q.delete();
        #1;
        chk("clr_valid", down_valid, 0);
        chk("clr_busy", busy, 0);
        chk("clr_credit", credit_count, 3);
        chk("clr_uf_kept", err_underflow, 1);
        drive_inst(32'h620, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("clr_blocks_accept", inst_ready, 0);
        clear = 1'b0;
        #1;
        chk("clr_release_accept", inst_ready, 1);
        inst_valid = 1'b0;

        // reset mid DRAIN
        drive_inst(32'h700, 3'b001, 1'b0, 1'b0, 1'b1);
        wait_accept("rstd_accept_timeout");
        finish_inst("rstd_done_timeout");
        chk("rstd_in_drain", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        drive_inst(32'h710, 3'b001, 1'b0, 1'b0, 1'b0);
        chk("rstd_busy", busy, 0);
        chk("rstd_valid", down_valid, 0);
        chk("rstd_group_done", group_done, 0);
        chk("rstd_inst_ready", inst_ready, 0);
        chk("rstd_ch_issue", ch_issue, 0);
        chk("rstd_credit", credit_count, 0);
        chk("rstd_uf", err_underflow, 0);
        chk("rstd_data", down_data, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstd_first_accept", inst_ready, 1);
        wait_accept("rstd_post_timeout");
        finish_inst("rstd_post_done_timeout");
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
